// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, buffer entry
// layout and the canonical NOP encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT_PEND,
        HALT
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic entry_t faultEntry(input logic [31:0] pc);
        faultEntry = '{inst: 32'h0, pc: pc, fault: 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, execute (redirects)
// and decode. The master side is the fetch unit itself.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush, used both as the
// instruction buffer and as the request-PC tag queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q;
    logic [AW-1:0]   rdPtr_q;
    logic [AW:0]     count_q;
    logic            doPush;
    logic            doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A push into a full FIFO is only honoured when the head leaves the same cycle.
    assign doPop  = pop_i && !empty_o && !flush_i;
    assign doPush = push_i && (!full_o || doPop) && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word requests under a credit limit,
// buffers returned words with their PC and handles redirects and faults.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   drop_q;

    logic [CW-1:0]   bufCount, tagCount;
    logic            bufFull, bufEmpty, tagFull, tagEmpty;
    entry_t          bufHead, bufData;
    logic [31:0]     tagHead;
    logic            reqValid, reqFire;
    logic            rspRetire, rspDrop, rspLive, rspAccept;
    logic            faultPush, bufPush, bufPop;

    // Credit counts in-flight requests including those already marked for dropping.
    assign reqValid  = (state_q == RUN) && !bus.redirect_valid && !tagFull
                       && ((outstanding_q + bufCount) < CW'(DEPTH));
    assign reqFire   = reqValid && bus.imem_req_ready;

    assign rspRetire = bus.imem_rsp_valid && (outstanding_q != '0);
    assign rspDrop   = rspRetire && (drop_q != '0);
    assign rspLive   = rspRetire && !bus.redirect_valid && (drop_q == '0);
    assign rspAccept = rspLive && (state_q == RUN) && !tagEmpty;
    assign faultPush = (state_q == FAULT_PEND) && (drop_q == '0) && !bus.redirect_valid;

    assign bufPush = rspAccept || faultPush;
    assign bufPop  = !bufEmpty && bus.inst_ready && !bus.redirect_valid;
    assign bufData = faultPush ? faultEntry(pc_q)
                   : '{inst:  bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data,
                       pc:    tagHead,
                       fault: bus.imem_rsp_err};

    fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) instBuf (
        .clk(clk), .rst_n(rst_n), .flush_i(bus.redirect_valid),
        .push_i(bufPush), .data_i(bufData), .pop_i(bufPop), .data_o(bufHead),
        .full_o(bufFull), .empty_o(bufEmpty), .count_o(bufCount)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) tagFifo (
        .clk(clk), .rst_n(rst_n), .flush_i(bus.redirect_valid),
        .push_i(reqFire), .data_i(pc_q), .pop_i(rspLive), .data_o(tagHead),
        .full_o(tagFull), .empty_o(tagEmpty), .count_o(tagCount)
    );

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = !bufEmpty;
    assign bus.inst           = bufEmpty ? 32'h0 : bufHead.inst;
    assign bus.inst_pc        = bufEmpty ? 32'h0 : bufHead.pc;
    assign bus.inst_fault     = !bufEmpty && bufHead.fault;

    // A redirect retires any same-cycle response as stale and drops the rest in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else if (bus.redirect_valid) begin
            pc_q          <= bus.redirect_pc;
            state_q       <= (bus.redirect_pc[1:0] != 2'b00) ? FAULT_PEND : RUN;
            outstanding_q <= outstanding_q - CW'(rspRetire);
            drop_q        <= outstanding_q - CW'(rspRetire);
        end else begin
            if (reqFire) pc_q <= pc_q + 32'd4;
            outstanding_q <= outstanding_q + CW'(reqFire) - CW'(rspRetire);
            if (rspDrop) drop_q <= drop_q - 1'b1;
            case (state_q)
                IDLE:       state_q <= RUN;
                RUN:        if (rspAccept && bus.imem_rsp_err) state_q <= HALT;
                FAULT_PEND: if (faultPush) state_q <= HALT;
                default:    state_q <= state_q;
            endcase
        end
    end

    // Tag queue holds exactly the live (not-to-be-dropped) requests.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && (outstanding_q == '0)));
    assert property (@(posedge clk) disable iff (!rst_n)
        (tagCount == (outstanding_q - drop_q)) && !(bufPush && bufFull && !bufPop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a variable-latency in-order
// instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    int          popCount = 0;
    int          reqCount = 0;
    int          rspDelay = 1;
    logic [31:0] expPc = 32'h0;
    logic        errEn = 1'b0;
    logic [31:0] errAddr = 32'h0;
    entry_t      expQ[$];
    memReq_t     memQ[$];

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a << 16) | NOP;
    endfunction

    function automatic entry_t goodEntry(input logic [31:0] a);
        return '{inst: memData(a), pc: a, fault: 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: every consumed instruction is matched against the expected queue.
    always @(negedge clk) begin
        entry_t actE, expE;
        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            actE = '{inst: bus.inst, pc: bus.inst_pc, fault: bus.inst_fault};
            popCount++;
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_inst: got pc=%h inst=%h fault=%b, expected none",
                         actE.pc, actE.inst, actE.fault);
            end else begin
                expE = expQ.pop_front();
                if (actE !== expE) begin
                    testsFailed++;
                    $display("[TB] FAIL inst_entry: got pc=%h inst=%h fault=%b, expected pc=%h inst=%h fault=%b",
                             actE.pc, actE.inst, actE.fault, expE.pc, expE.inst, expE.fault);
                end
            end
        end
    end

    // Request monitor: addresses must follow the architectural PC sequence.
    always @(negedge clk) begin
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            checkOutput("req_addr", bus.imem_req_addr, expPc);
            memQ.push_back('{addr: bus.imem_req_addr, due: cyc + rspDelay});
            expPc = expPc + 32'd4;
            reqCount++;
        end
    end

    // In-order memory: answers each accepted request rspDelay cycles later.
    always @(posedge clk) begin
        memReq_t m;
        cyc++;
        #1;
        if (!rst_n) begin
            memQ.delete();
            bus.imem_rsp_valid = 1'b0;
        end else if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            m = memQ.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memData(m.addr);
            bus.imem_rsp_err   = errEn && (m.addr == errAddr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
            bus.imem_rsp_err   = 1'b0;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        #1;
        checkOutput("no_req_in_redirect", {31'h0, bus.imem_req_valid}, 32'h0);
        expPc = pc;
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic consume(input int n);
        int target;
        target = popCount + n;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 300 && popCount < target; i++) begin
            @(posedge clk);
            #2;
        end
        bus.inst_ready = 1'b0;
        checkOutput("consume_done", {31'h0, popCount >= target}, 32'h1);
        checkOutput("sb_drained", expQ.size(), 32'h0);
    endtask

    task automatic checkSilent(input string name, input int n);
        logic sawReq;
        sawReq = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (bus.imem_req_valid) sawReq = 1'b1;
        end
        checkOutput(name, {31'h0, sawReq}, 32'h0);
        checkOutput({name, "_inst"}, {31'h0, bus.inst_valid}, 32'h0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_req_valid"},  {31'h0, bus.imem_req_valid}, 32'h0);
        checkOutput({name, "_inst_valid"}, {31'h0, bus.inst_valid}, 32'h0);
        checkOutput({name, "_inst"},       bus.inst, 32'h0);
        checkOutput({name, "_inst_pc"},    bus.inst_pc, 32'h0);
        checkOutput({name, "_inst_fault"}, {31'h0, bus.inst_fault}, 32'h0);
    endtask

    initial begin
        int r0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        checkAllZero("reset");

        // Streaming from reset: first instruction three cycles after release.
        expQ.push_back(goodEntry(32'h0));
        expQ.push_back(goodEntry(32'h4));
        expQ.push_back(goodEntry(32'h8));
        bus.inst_ready = 1'b1;
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("c1_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        checkOutput("c1_req_addr", bus.imem_req_addr, 32'h0);
        waitCycles(1);
        checkOutput("c2_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        checkOutput("c2_req_addr", bus.imem_req_addr, 32'h4);
        checkOutput("c2_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        waitCycles(1);
        checkOutput("c3_inst_valid", {31'h0, bus.inst_valid}, 32'h1);
        checkOutput("c3_inst_pc", bus.inst_pc, 32'h0);
        consume(3);

        // Decode stalled: credit limit caps requests, then drain in order.
        r0 = reqCount;
        waitCycles(10);
        checkOutput("stall_req_limit", {31'h0, (reqCount - r0) <= 2}, 32'h1);
        checkOutput("stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        checkOutput("stall_inst_valid", {31'h0, bus.inst_valid}, 32'h1);
        expQ.push_back(goodEntry(32'hC));
        expQ.push_back(goodEntry(32'h10));
        expQ.push_back(goodEntry(32'h14));
        expQ.push_back(goodEntry(32'h18));
        consume(4);
        waitCycles(5);

        // Two slow requests in flight, then redirect: both responses dropped.
        rspDelay = 4;
        applyStimulus(32'h10);
        waitCycles(2);
        checkOutput("two_outstanding_stall", {31'h0, bus.imem_req_valid}, 32'h0);
        applyStimulus(32'h100);
        expQ.push_back(goodEntry(32'h100));
        expQ.push_back(goodEntry(32'h104));
        consume(2);
        rspDelay = 1;
        waitCycles(8);

        // Access fault on 0x8 halts fetch until the next redirect.
        errEn = 1'b1;
        errAddr = 32'h8;
        applyStimulus(32'h0);
        expQ.push_back(goodEntry(32'h0));
        expQ.push_back(goodEntry(32'h4));
        expQ.push_back(faultEntry(32'h8));
        consume(3);
        checkSilent("halt_no_req", 6);
        errEn = 1'b0;
        applyStimulus(32'h40);
        expQ.push_back(goodEntry(32'h40));
        expQ.push_back(goodEntry(32'h44));
        consume(2);
        waitCycles(5);

        // Misaligned redirect with one request outstanding.
        rspDelay = 3;
        applyStimulus(32'h20);
        waitCycles(1);
        applyStimulus(32'h102);
        expQ.push_back(faultEntry(32'h102));
        consume(1);
        checkSilent("misalign_no_req", 8);

        // Asynchronous reset with a full buffer, then restart at RESET_PC.
        rspDelay = 1;
        applyStimulus(32'h200);
        waitCycles(6);
        checkOutput("full_before_reset", {31'h0, bus.inst_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        repeat (2) @(posedge clk);
        #2;
        expPc = 32'h0;
        expQ.push_back(goodEntry(32'h0));
        expQ.push_back(goodEntry(32'h4));
        rst_n = 1'b1;
        consume(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
